// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bus between the CPU data port (master) and
// the memory responder (slave).
//   data_req/data_wr/data_wstrb/data_addr/data_wdata : request, master -> slave
//   data_addr_ok                                      : request accepted, slave -> master
//   data_data_ok/data_rdata                           : in-order response, slave -> master
interface data_sram_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory responder: byte-strobed word array with an in-order
// response queue of DEPTH entries, each response issued LATENCY cycles
// after its acceptance edge.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset (queue only; the array keeps its contents)
//   bus    : slave end of the data-SRAM request/response interface
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DEPTH      = 2
) (
  input logic                  clk,
  input logic                  resetn,
  data_sram_responder_if.slave bus
);

  localparam int unsigned NWORDS = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TMR_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NBYTES = 4;

  // Word array and response queue state
  logic [DATA_W-1:0]     r_mem [NWORDS];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_is_read;
  logic [DATA_W-1:0]     r_rdata [DEPTH];
  logic [TMR_W-1:0]      r_timer [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_addr_ok;
  logic                  w_accept;
  logic                  w_data_ok;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Byte offset and high address bits alias onto the same word
  assign w_idx    = bus.data_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^{bus.data_addr[31:ADDR_WIDTH+2], bus.data_addr[1:0]};

  // Handshake: accept only from registered count, so a same-cycle retire never frees a slot
  assign w_addr_ok = resetn && (r_count < CNT_W'(DEPTH));
  assign w_accept  = bus.data_req && w_addr_ok;
  assign w_data_ok = (r_count != '0) && (r_timer[r_head] == '0);

  assign bus.data_addr_ok = w_addr_ok;
  assign bus.data_data_ok = w_data_ok;
  assign bus.data_rdata   = (w_data_ok && r_is_read[r_head]) ? r_rdata[r_head] : '0;

  // Array write at the acceptance edge; the array is deliberately never reset
  always_ff @(posedge clk) begin : mem_write
    if (w_accept && bus.data_wr) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.data_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response queue: timers count down, head pops on response, tail pushes on accept
  always_ff @(posedge clk or negedge resetn) begin : resp_queue
    if (!resetn) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_is_read <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rdata[i] <= '0;
        r_timer[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_timer[i] != '0)) begin
          r_timer[i] <= r_timer[i] - TMR_W'(1);
        end
      end

      if (w_data_ok) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end

      // Tail slot is free (not valid), so it never collides with the decrement above
      if (w_accept) begin
        r_valid[r_tail]   <= 1'b1;
        r_is_read[r_tail] <= !bus.data_wr;
        r_rdata[r_tail]   <= bus.data_wr ? '0 : r_mem[w_idx];
        r_timer[r_tail]   <= TMR_W'(LATENCY - 1);
        r_tail            <= ptr_inc(r_tail);
      end

      if (w_accept && !w_data_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_accept && w_data_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam int NDUT = 3;

  // Reference model entry: response due in cycle 'due'
  typedef struct {
    int          due;
    bit          is_rd;
    logic [31:0] data;
    logic [3:0]  known;
  } ent_t;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int dep_of(input int d);
    case (d)
      0:       return 2;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        req [NDUT];
  logic        wr;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        aok [NDUT];
  logic        dok [NDUT];
  logic [31:0] rd  [NDUT];

  data_sram_responder_if bus0 ();
  data_sram_responder_if bus1 ();
  data_sram_responder_if bus2 ();

  assign bus0.data_req = req[0];
  assign bus1.data_req = req[1];
  assign bus2.data_req = req[2];
  assign bus0.data_wr = wr;    assign bus1.data_wr = wr;    assign bus2.data_wr = wr;
  assign bus0.data_wstrb = strb; assign bus1.data_wstrb = strb; assign bus2.data_wstrb = strb;
  assign bus0.data_addr = addr;  assign bus1.data_addr = addr;  assign bus2.data_addr = addr;
  assign bus0.data_wdata = wdata; assign bus1.data_wdata = wdata; assign bus2.data_wdata = wdata;
  assign aok[0] = bus0.data_addr_ok; assign dok[0] = bus0.data_data_ok; assign rd[0] = bus0.data_rdata;
  assign aok[1] = bus1.data_addr_ok; assign dok[1] = bus1.data_data_ok; assign rd[1] = bus1.data_rdata;
  assign aok[2] = bus2.data_addr_ok; assign dok[2] = bus2.data_data_ok; assign rd[2] = bus2.data_rdata;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DEPTH(2)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave));
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .DEPTH(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave));
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(4), .DEPTH(4)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave));

  // Scoreboard state
  ent_t        mq [NDUT][$];
  logic [31:0] mmem   [NDUT][1024];
  logic [3:0]  mknown [NDUT][1024];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          acc     [NDUT];
  int          acc_cyc [NDUT];
  int          dok_cnt [NDUT];
  logic [31:0] last_rd [NDUT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-level reference model, evaluated mid-cycle with inputs stable
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      bit          e_aok;
      bit          e_dok;
      logic [31:0] e_rd;
      logic [31:0] m;
      logic [3:0]  k;
      int          idx;
      ent_t        e;

      if (!resetn) mq[d].delete();
      e_aok = resetn && (mq[d].size() < dep_of(d));
      e_dok = resetn && (mq[d].size() > 0) && (mq[d][0].due == cyc);
      e_rd  = 32'h0;
      m     = 32'hFFFF_FFFF;
      if (e_dok && mq[d][0].is_rd) begin
        e_rd = mq[d][0].data;
        k    = mq[d][0].known;
        m    = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
      end

      chk($sformatf("addr_ok[%0d]", d), 32'(aok[d]), 32'(e_aok));
      chk($sformatf("data_ok[%0d]", d), 32'(dok[d]), 32'(e_dok));
      if (m != 32'h0) chk($sformatf("rdata[%0d]", d), rd[d] & m, e_rd & m);

      if (dok[d]) begin
        dok_cnt[d]++;
        last_rd[d] = rd[d];
      end

      acc[d] = 1'b0;
      if (resetn) begin
        if (e_dok) void'(mq[d].pop_front());
        if (req[d] && e_aok) begin
          acc[d]     = 1'b1;
          acc_cyc[d] = cyc;
          idx        = int'(addr[11:2]);
          e.due      = cyc + lat_of(d);
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (strb[b]) mmem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            mknown[d][idx] = mknown[d][idx] | strb;
            e.is_rd = 1'b0;
            e.data  = 32'h0;
            e.known = 4'hF;
          end else begin
            e.is_rd = 1'b1;
            e.data  = mmem[d][idx];
            e.known = mknown[d][idx];
          end
          mq[d].push_back(e);
        end
      end
    end
  end

  // Present one request to every DUT and hold it until each has accepted it
  task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] dat);
    int pend;
    wr = w; strb = s; addr = a; wdata = dat;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b1;
    pend = NDUT;
    for (int n = 0; n < 40 && pend != 0; n++) begin
      @(posedge clk); #1;
      pend = 0;
      for (int d = 0; d < NDUT; d++) begin
        if (acc[d]) req[d] = 1'b0;
        if (req[d]) pend++;
      end
    end
    if (pend != 0) begin
      chk("issue_timeout", 32'(pend), 32'd0);
      for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
    end
  endtask

  task automatic drain();
    int left;
    left = 1;
    for (int n = 0; n < 30 && left != 0; n++) begin
      @(posedge clk); #1;
      left = 0;
      for (int d = 0; d < NDUT; d++) left += mq[d].size();
    end
    if (left != 0) chk("drain_timeout", 32'(left), 32'd0);
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, 4'h0, a, 32'h0);
    drain();
    for (int d = 0; d < NDUT; d++) chk($sformatf("%s[%0d]", tag, d), last_rd[d], exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0   [NDUT];
    int base [NDUT];

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 1024; i++) begin
        mknown[d][i] = 4'h0;
        mmem[d][i]   = 32'h0;
      end
      acc[d] = 1'b0; acc_cyc[d] = 0; dok_cnt[d] = 0; last_rd[d] = 32'h0;
      req[d] = 1'b1;
    end
    wr = 1'b0; strb = 4'hF; addr = 32'h10; wdata = 32'h0;

    // Reset held with requests pending
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;

    // Write then read, then byte strobes
    issue(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    drain();
    read_expect("rd_full", 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344);
    drain();
    read_expect("rd_strb", 32'h0000_0010, 32'hDE22_BE44);

    // Three back-to-back reads against a two-deep queue
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    for (int d = 0; d < NDUT; d++) t0[d] = acc_cyc[d];
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    chk("full_gap[0]", 32'(acc_cyc[0] - t0[0]), 32'd2);
    chk("full_gap[1]", 32'(acc_cyc[1] - t0[1]), 32'd4);
    chk("full_gap[2]", 32'(acc_cyc[2] - t0[2]), 32'd2);
    drain();

    // Reset while a read is in flight: its response must never appear
    for (int d = 0; d < NDUT; d++) base[d] = dok_cnt[d];
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("rst_drop[%0d]", d), 32'(dok_cnt[d] - base[d]), (lat_of(d) == 1) ? 32'd1 : 32'd0);
    read_expect("rd_after_rst", 32'h0000_0010, 32'hDE22_BE44);

    // Address aliasing
    issue(1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D);
    drain();
    read_expect("alias4", 32'h0000_0004, 32'hCAFE_F00D);
    read_expect("alias6", 32'h0000_0006, 32'hCAFE_F00D);

    // Random traffic over a small aliased word set, with occasional resets
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      resetn = ($urandom_range(0, 99) != 0);
      for (int d = 0; d < NDUT; d++) req[d] = ($urandom_range(0, 3) != 0);
      wr    = $urandom_range(0, 1) != 0;
      strb  = 4'($urandom_range(0, 15));
      addr  = {20'($urandom), 7'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wdata = $urandom;
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
